subtrator_serial: RTL
=====================

// Module: subtrator_serial
// PURPOSE
//  Bit-serial inverse of the somador adder: recovers a = soma - b, one bit per clock, LSB first.
//  Consumes the somador output plus its b operand; gives a hardware round-trip check (a + b == soma).
//  Uses a start/busy/done handshake with a controlling FSM or test driver.
//  Small area: one full-subtractor cell, one borrow flop, shift registers and a bit counter.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2); matches somador's 4-bit datapath by default
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled on rising clk edge, accepted only in IDLE or DONE
//  soma    in   WIDTH  minuend, captured on accepted start
//  b       in   WIDTH  subtrahend, captured on accepted start
//  busy    out  1      1 while in SHIFT
//  done    out  1      one-cycle pulse: a/borrow just updated
//  a       out  WIDTH  result register; holds last result until next completion
//  borrow  out  1      final borrow: 1 iff soma < b (unsigned), i.e. result wrapped
//  ovf     out  1      present only with SUBTRATOR_OVF_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: clk and rst only as named above; rst is async active-high.
//   - Asserting rst forces busy=0, done=0, a=0, borrow=0, ovf=0, state=IDLE, counter=0 immediately.
//   - Reset mid-operation discards the pending operation; no done pulse follows.
//  FSM states IDLE, SHIFT, DONE:
//   - IDLE: start=1 -> latch soma/b into shift regs, clear internal borrow, cnt=0 -> SHIFT.
//   - SHIFT: each edge processes bit cnt:
//       d  = s0 ^ b0 ^ br
//       br = (~s0 & b0) | (~(s0 ^ b0) & br)
//     Shift d into result shadow reg from MSB; shift operand regs right; cnt++.
//     When cnt reaches WIDTH-1 (last bit): copy shadow to a, final br to borrow -> DONE.
//   - DONE: done=1 for exactly this cycle.
//       start=1 -> accepted (same as IDLE) -> SHIFT.
//       else -> IDLE.
//  Latency: start sampled at edge T0; bits at edges T1..T(WIDTH); done high in cycle after T(WIDTH).
//   With WIDTH=4, done is high 4 cycles after the start edge.
//   Back-to-back throughput is one op per WIDTH+1 cycles.
//  Handshake:
//   - start while busy=1 is ignored (no queueing); soma/b changes during SHIFT have no effect.
//  Outputs:
//   - a and borrow change only on the SHIFT->DONE edge; they are stable during SHIFT and IDLE.
//   - busy = (state==SHIFT) and is registered.
//  Arithmetic: modulo 2^WIDTH.
//   - Wrap-around (soma<b) gives a = soma - b + 2^WIDTH with borrow=1.
//   - soma==b gives a=0, borrow=0.
// CONFIGURATION
//  SUBTRATOR_OVF_EN defined:
//   - Adds port ovf: signed two's-complement overflow of soma - b.
//   - ovf = (soma[MSB] != b[MSB]) && (a[MSB] != soma[MSB]), using the captured operands.
//   - Updated together with a; reset 0.
//  SUBTRATOR_OVF_EN undefined:
//   - ovf port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. rst=1 then release, start=0 -> busy=0, done=0, a=0000, borrow=0 for 10 cycles.
//  2. soma=3, b=1, start pulse -> busy=1 for 4 cycles; done pulse 4 cycles after start edge; a=0010, borrow=0.
//  3. soma=0, b=1 -> a=1111, borrow=1 (wrap).
//     soma=5, b=10 -> a=1011, borrow=1 (10+11=21 mod 16=5).
//  4. Start during SHIFT with soma=15, b=0 -> ignored; first result still delivered.
//     Start held high in DONE -> new op begins, next done 5 cycles after previous done.
//  5. rst pulsed at 2nd SHIFT cycle -> all outputs 0 at once, no done pulse.
//     Next op soma=9, b=8 -> a=0001.
//  6. With SUBTRATOR_OVF_EN:
//     soma=8 (-8), b=1 -> a=0111, ovf=1.
//     soma=3, b=1 -> ovf=0.
//     Without the macro, the build elaborates with no ovf port.

Source files
------------

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial subtractor, a = soma - b (mod 2^WIDTH), LSB first.
// One full-subtractor cell, one borrow flop, operand shift registers and a bit
// counter, sequenced by a small IDLE/SHIFT/DONE FSM with a start/busy/done handshake.
//
// Optional build macro: SUBTRATOR_OVF_EN
//   defined   -> adds output ovf (signed two's-complement overflow of soma - b)
//   undefined -> no ovf port and no overflow logic
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; a/borrow hold the last result
//   S_SHIFT | one bit per clock through the full-subtractor cell
//   S_DONE  | a/borrow just updated, done high for this single cycle

module subtrator_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] soma,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             borrow
`ifdef SUBTRATOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s_q;       // minuend shift register, LSB consumed first
  logic [WIDTH-1:0] b_q;       // subtrahend shift register
  logic [WIDTH-1:0] res_q;     // result shadow, filled from the MSB side
  logic [CW-1:0]    cnt_q;
  logic             br_q;      // running borrow between bit positions
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] a_q;
  logic             borrow_q;

  logic             diff_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

`ifdef SUBTRATOR_OVF_EN
  // Operand sign bits are shifted out of s_q/b_q, so keep a copy for the overflow test.
  logic             s_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
`endif

  // Full-subtractor cell on the current LSBs plus the shadow register's next value.
  always_comb begin
    diff_d = s_q[0] ^ b_q[0] ^ br_q;
    br_d   = (~s_q[0] & b_q[0]) | (~(s_q[0] ^ b_q[0]) & br_q);
    res_d  = {diff_d, res_q[WIDTH-1:1]};
  end

  // Controlling FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      s_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      borrow_q <= 1'b0;
`ifdef SUBTRATOR_OVF_EN
      s_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            s_q     <= soma;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
`ifdef SUBTRATOR_OVF_EN
            s_msb_q <= soma[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_SHIFT: begin
          s_q   <= s_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          // Last bit: the completed word (including this bit) goes straight to a.
          if (cnt_q == CNT_LAST) begin
            a_q      <= res_d;
            borrow_q <= br_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
`ifdef SUBTRATOR_OVF_EN
            ovf_q    <= (s_msb_q != b_msb_q) && (diff_d != s_msb_q);
`endif
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a      = a_q;
  assign borrow = borrow_q;
`ifdef SUBTRATOR_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
